mmio_ctrl_wait: RTL and testbench

- Parametrised successor to the fixed 64-slot MMIO controller: decodes the FPro MMIO bus into N_SLOT slots, each REG_AW registers deep.
- Adds a per-slot ready/wait handshake, a bus timeout watchdog, slot-enable masking with error responses, and a registered response path.
- Sits between the CPU MMIO bus and the slot cores in the MMIO subsystem, so slow cores (SPI, XADC) can stall the bus.

---
 rtl/mmio_ctrl_wait.sv | 214 +++++++++++++++++++++
 tb/tb_mmio_ctrl_wait.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_ctrl_wait.sv
// mmio_ctrl_wait: MMIO bus decoder for N_SLOT slots of REG_AW registers each.
// Each access is a one-cycle slot strobe, then an optional wait for the
// selected slot's ready bit, bounded by a TIMEOUT watchdog. Unpopulated
// slots and timeouts produce an error response. The response is a
// one-cycle mmio_ready pulse.
//
// Handshake: a request is taken only in IDLE, when mmio_cs & (mmio_rd | mmio_wr).
// The master then holds off until the mmio_ready pulse. mmio_rd_data and
// bus_err are 0 outside that pulse.
//
// Optional build macro MMIO_ERR_LOG_EN adds the error log outputs
// err_addr and err_cnt and the err_clr input.
// fsm_state exposes the controller state for observation:
// 0 = IDLE, 1 = ACCESS, 2 = WAIT, 3 = RESP.
module mmio_ctrl_wait #(
  parameter int          N_SLOT    = 64,
  parameter int          REG_AW    = 5,
  parameter logic [63:0] SLOT_MASK = {64{1'b1}},
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mmio_cs,
  input  logic                 mmio_wr,
  input  logic                 mmio_rd,
  input  logic [20:0]          mmio_addr,
  input  logic [31:0]          mmio_wr_data,
  output logic [31:0]          mmio_rd_data,
  output logic                 mmio_ready,
  output logic                 bus_err,
  output logic [N_SLOT-1:0]    slot_cs_array,
  output logic [N_SLOT-1:0]    slot_mem_rd_array,
  output logic [N_SLOT-1:0]    slot_mem_wr_array,
  output logic [REG_AW-1:0]    slot_reg_addr,
  output logic [31:0]          slot_wr_data,
  input  logic [N_SLOT*32-1:0] slot_rd_data_1d,
  input  logic [N_SLOT-1:0]    slot_ready_array,
`ifdef MMIO_ERR_LOG_EN
  input  logic                 err_clr,
  output logic [20:0]          err_addr,
  output logic [15:0]          err_cnt,
`endif
  output logic [1:0]           fsm_state
);

  localparam int SLOT_AW = $clog2(N_SLOT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t              state, state_next;
  logic [SLOT_AW-1:0]  sel;
  logic [REG_AW-1:0]   reg_q;
  logic [31:0]         wdata_q;
  logic                op_wr;
  logic                err_q;
  logic [31:0]         resp_data;
  logic [7:0]          cnt;

  logic                req;
  logic [SLOT_AW-1:0]  req_slot;
  logic                req_pop;
  logic                sel_ready;
  logic [31:0]         sel_data;
  logic                fin_ok;
  logic                fin_err;
  logic                wr_now;
  logic                unused_addr_bits;

  // Only [REG_AW+SLOT_AW-1:0] of the address is decoded; the rest is don't-care.
  assign unused_addr_bits = ^mmio_addr;

  assign req       = mmio_cs & (mmio_rd | mmio_wr);
  assign req_slot  = mmio_addr[REG_AW +: SLOT_AW];
  assign req_pop   = SLOT_MASK[req_slot];
  assign sel_ready = slot_ready_array[sel];
  assign sel_data  = slot_rd_data_1d[{sel, 5'd0} +: 32];
  // An unpopulated-slot error is decided in IDLE, before op_wr is latched.
  assign wr_now    = (state == IDLE) ? mmio_wr : op_wr;
  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. It also flags how the access finishes (ok or error).
  always_comb begin
    state_next = state;
    fin_ok     = 1'b0;
    fin_err    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_pop) begin
            state_next = ACCESS;
          end else begin
            state_next = RESP;
            fin_err    = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_next = RESP;
          fin_ok     = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Ready takes priority over a timeout in the same cycle.
        if (sel_ready) begin
          state_next = RESP;
          fin_ok     = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_next = RESP;
          fin_err    = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      op_wr     <= 1'b0;
      err_q     <= 1'b0;
      resp_data <= '0;
      cnt       <= '0;
    end else begin
      if (state == IDLE && req) begin
        sel     <= req_slot;
        reg_q   <= mmio_addr[REG_AW-1:0];
        wdata_q <= mmio_wr_data;
        op_wr   <= mmio_wr;
      end
      if (state == WAIT) cnt <= cnt + 8'd1;
      else               cnt <= '0;
      if (fin_ok) begin
        resp_data <= op_wr ? 32'd0 : sel_data;
        err_q     <= 1'b0;
      end else if (fin_err) begin
        resp_data <= wr_now ? 32'd0 : ERR_DATA;
        err_q     <= 1'b1;
      end
    end
  end

  // Output decode: slot strobes in ACCESS, response pulse in RESP.
  always_comb begin
    slot_cs_array     = '0;
    slot_mem_rd_array = '0;
    slot_mem_wr_array = '0;
    mmio_ready        = 1'b0;
    mmio_rd_data      = '0;
    bus_err           = 1'b0;
    if (state == ACCESS) begin
      slot_cs_array[sel]     = 1'b1;
      slot_mem_rd_array[sel] = ~op_wr;
      slot_mem_wr_array[sel] = op_wr;
    end
    if (state == RESP) begin
      mmio_ready   = 1'b1;
      mmio_rd_data = resp_data;
      bus_err      = err_q;
    end
  end

  assign slot_reg_addr = reg_q;
  assign slot_wr_data  = wdata_q;

`ifdef MMIO_ERR_LOG_EN
  logic [20:0] addr_q;
  logic        err_seen;
  logic        err_event;

  assign err_event = (state == RESP) & err_q;

  // Full request address, kept for the error log.
  always_ff @(posedge clk) begin
    if (reset)                     addr_q <= '0;
    else if (state == IDLE && req) addr_q <= mmio_addr;
  end

  // Sticky first-error address and saturating error count; a clear wins,
  // then an error in the same cycle becomes the new first error.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr <= '0;
      err_cnt  <= '0;
      err_seen <= 1'b0;
    end else if (err_clr) begin
      err_addr <= err_event ? addr_q : 21'd0;
      err_cnt  <= err_event ? 16'd1 : 16'd0;
      err_seen <= err_event;
    end else if (err_event) begin
      if (!err_seen) begin
        err_addr <= addr_q;
        err_seen <= 1'b1;
      end
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_ctrl_wait.sv
// tb_mmio_ctrl_wait: directed bench for mmio_ctrl_wait.
// Main instance: 64 slots, slot 12 unpopulated. A second instance has
// 16 slots and REG_AW = 4. The driver pushes {expected cycle, err, data}
// per request; monitors pop and compare on every mmio_ready pulse.
module tb_mmio_ctrl_wait;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance (64 slots) ----------------
  logic          mmio_cs = 0, mmio_wr = 0, mmio_rd = 0;
  logic [20:0]   mmio_addr = '0;
  logic [31:0]   mmio_wr_data = '0;
  logic [31:0]   mmio_rd_data;
  logic          mmio_ready, bus_err;
  logic [63:0]   slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
  logic [4:0]    slot_reg_addr;
  logic [31:0]   slot_wr_data;
  logic [2047:0] slot_rd_data_1d;
  logic [63:0]   slot_ready_array = {64{1'b1}};
  logic [1:0]    fsm_state;
`ifdef MMIO_ERR_LOG_EN
  logic          err_clr = 1'b0;
  logic [20:0]   err_addr;
  logic [15:0]   err_cnt;
`endif

  for (genvar g = 0; g < 64; g++) begin : g_sdata
    assign slot_rd_data_1d[32*g +: 32] = (g == 3) ? 32'h000000A5 : (32'h51000000 | 32'(g));
  end

  mmio_ctrl_wait #(
    .N_SLOT(64), .REG_AW(5), .SLOT_MASK(64'hFFFF_FFFF_FFFF_EFFF),
    .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)
  ) u_dut (
    .clk(clk), .reset(reset), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .mmio_ready(mmio_ready), .bus_err(bus_err), .slot_cs_array(slot_cs_array),
    .slot_mem_rd_array(slot_mem_rd_array), .slot_mem_wr_array(slot_mem_wr_array),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
    .slot_rd_data_1d(slot_rd_data_1d), .slot_ready_array(slot_ready_array),
`ifdef MMIO_ERR_LOG_EN
    .err_clr(err_clr), .err_addr(err_addr), .err_cnt(err_cnt),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- second instance (16 slots, REG_AW = 4) ----------------
  logic         cs16 = 0, rd16 = 0;
  logic [20:0]  addr16 = '0;
  logic [31:0]  rdata16;
  logic         ready16, err16;
  logic [15:0]  cs_arr16, rd_arr16, wr_arr16;
  logic [3:0]   reg16;
  logic [31:0]  wdata16;
  logic [511:0] sdata16;
  logic [15:0]  sready16 = 16'hFFFF;
  logic [1:0]   state16;
`ifdef MMIO_ERR_LOG_EN
  logic [20:0]  err_addr16;
  logic [15:0]  err_cnt16;
`endif

  for (genvar g = 0; g < 16; g++) begin : g_sdata16
    assign sdata16[32*g +: 32] = 32'h16000000 | 32'(g);
  end

  mmio_ctrl_wait #(.N_SLOT(16), .REG_AW(4), .TIMEOUT(16)) u_dut16 (
    .clk(clk), .reset(reset), .mmio_cs(cs16), .mmio_wr(1'b0), .mmio_rd(rd16),
    .mmio_addr(addr16), .mmio_wr_data(32'd0), .mmio_rd_data(rdata16),
    .mmio_ready(ready16), .bus_err(err16), .slot_cs_array(cs_arr16),
    .slot_mem_rd_array(rd_arr16), .slot_mem_wr_array(wr_arr16),
    .slot_reg_addr(reg16), .slot_wr_data(wdata16),
    .slot_rd_data_1d(sdata16), .slot_ready_array(sready16),
`ifdef MMIO_ERR_LOG_EN
    .err_clr(1'b0), .err_addr(err_addr16), .err_cnt(err_cnt16),
`endif
    .fsm_state(state16)
  );

  // ---------------- scoreboard ----------------
  logic [48:0] exp_q[$];
  logic [48:0] exp16_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the main instance: response contents and timing.
  always @(negedge clk) begin
    if (!reset && mmio_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        logic [48:0] e;
        e = exp_q.pop_front();
        chk("resp_cycle", 64'(cyc[15:0]), 64'(e[48:33]));
        chk("resp_err", 64'(bus_err), 64'(e[32]));
        chk("resp_data", 64'(mmio_rd_data), 64'(e[31:0]));
      end
    end else if (!reset) begin
      chk("idle_zero", {31'd0, bus_err, mmio_rd_data}, 64'd0);
    end
  end

  // Monitor for the 16-slot instance.
  always @(negedge clk) begin
    if (!reset && ready16 === 1'b1) begin
      if (exp16_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready16: got ready at cycle %0d expected none", cyc);
      end else begin
        logic [48:0] e;
        e = exp16_q.pop_front();
        chk("resp16_cycle", 64'(cyc[15:0]), 64'(e[48:33]));
        chk("resp16_err", 64'(err16), 64'(e[32]));
        chk("resp16_data", 64'(rdata16), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT in IDLE. delay: 0 = slot ready at
  // strobe, k > 0 = ready k cycles after the strobe, -1 = never ready.
  task automatic do_req(input logic rd, input logic wr, input logic [20:0] addr,
                        input logic [31:0] wdata, input int delay,
                        input logic [31:0] exp_data, input logic exp_err, input int lat);
    int   slot;
    logic pop;
    int   n;
    slot = int'(addr[10:5]);
    pop  = (slot != 12);
    if (delay != 0) slot_ready_array[slot] = 1'b0;
    mmio_cs = 1'b1; mmio_rd = rd; mmio_wr = wr;
    mmio_addr = addr; mmio_wr_data = wdata;
    exp_q.push_back({16'(cyc + lat), exp_err, exp_data});
    @(negedge clk);
    mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
    chk("cs_strobe", slot_cs_array, pop ? (64'd1 << slot) : 64'd0);
    chk("rd_strobe", slot_mem_rd_array, (pop && !wr) ? (64'd1 << slot) : 64'd0);
    chk("wr_strobe", slot_mem_wr_array, (pop && wr) ? (64'd1 << slot) : 64'd0);
    if (pop) chk("reg_addr", 64'(slot_reg_addr), 64'(addr[4:0]));
    if (pop && wr) chk("wr_data", 64'(slot_wr_data), 64'(wdata));
    if (delay > 0) begin
      repeat (delay) begin
        @(negedge clk);
        chk("wait_no_strobe", slot_cs_array | slot_mem_rd_array | slot_mem_wr_array, 64'd0);
        if (wr) chk("wr_data_held", 64'(slot_wr_data), 64'(wdata));
      end
      slot_ready_array[slot] = 1'b1;
    end
    n = 0;
    while (mmio_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (mmio_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready expected ready for addr %h", addr);
    end
    slot_ready_array[slot] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int t;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(mmio_ready), 64'd0);
    chk("rst_strobes", slot_cs_array | slot_mem_rd_array | slot_mem_wr_array, 64'd0);
    chk("rst_regs", {27'd0, slot_reg_addr, slot_wr_data}, 64'd0);
    chk("rst_state", 64'(fsm_state), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait read of slot 3 reg 2.
    do_req(1'b1, 1'b0, 21'h062, 32'h0, 0, 32'h000000A5, 1'b0, 2);
    // rd and wr both high: treated as a write.
    do_req(1'b1, 1'b1, 21'h061, 32'hCAFEF00D, 0, 32'h0, 1'b0, 2);
    // Write to slot 9, ready 4 cycles after the strobe.
    do_req(1'b0, 1'b1, 21'h120, 32'h12345678, 4, 32'h0, 1'b0, 6);
    // Read of unpopulated slot 12.
    do_req(1'b1, 1'b0, 21'h180, 32'h0, 0, 32'hDEADBEEF, 1'b1, 1);
`ifdef MMIO_ERR_LOG_EN
    chk("err_addr_first", 64'(err_addr), 64'h180);
    chk("err_cnt_1", 64'(err_cnt), 64'd1);
`endif
    // Read of slot 5 that never becomes ready: timeout.
    do_req(1'b1, 1'b0, 21'h0A0, 32'h0, -1, 32'hDEADBEEF, 1'b1, 18);
    // Write to unpopulated slot: error with zero data.
    do_req(1'b0, 1'b1, 21'h181, 32'h55AA55AA, 0, 32'h0, 1'b1, 1);
`ifdef MMIO_ERR_LOG_EN
    chk("err_addr_sticky", 64'(err_addr), 64'h180);
    chk("err_cnt_3", 64'(err_cnt), 64'd3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", {27'd0, err_addr, err_cnt}, 64'd0);
`endif
    // Next request after the error responses is accepted normally.
    do_req(1'b1, 1'b0, 21'h062, 32'h0, 0, 32'h000000A5, 1'b0, 2);

    // Reset while in WAIT: no response may appear.
    slot_ready_array[5] = 1'b0;
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = 21'h0A0;
    @(negedge clk);
    mmio_cs = 1'b0; mmio_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_wait", 64'(fsm_state), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", 64'(fsm_state), 64'd0);
    chk("abort_outputs", {31'd0, mmio_ready, bus_err, mmio_rd_data}, 64'd0);
    chk("abort_strobes", slot_cs_array | slot_mem_rd_array | slot_mem_wr_array, 64'd0);
    slot_ready_array[5] = 1'b1;
    // Read slot 0 reg 1 right after reset is released.
    do_req(1'b1, 1'b0, 21'h001, 32'h0, 0, 32'h51000000, 1'b0, 2);
    repeat (20) @(negedge clk);

    // 16-slot instance: slot 15 reg 3, ready on the timeout cycle.
    sready16[15] = 1'b0;
    cs16 = 1'b1; rd16 = 1'b1; addr16 = 21'h0F3;
    t = cyc;
    exp16_q.push_back({16'(t + 18), 1'b0, 32'h1600000F});
    @(negedge clk);
    cs16 = 1'b0; rd16 = 1'b0;
    chk("cs16_strobe", 64'(cs_arr16), 64'h8000);
    chk("rd16_strobe", 64'(rd_arr16), 64'h8000);
    chk("reg16_addr", 64'(reg16), 64'd3);
    repeat (16) @(negedge clk);
    sready16[15] = 1'b1;
    n = 0;
    while (ready16 !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (ready16 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready16_timeout: got no ready expected ready at cycle %0d", t + 18);
    end
    repeat (3) @(negedge clk);

    if (exp_q.size() != 0 || exp16_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size() + exp16_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
